fp_square: RTL and testbench

Single-precision IEEE-754 squaring unit: computes in1 × in1 with the same five rounding modes and the same exception flags as the square-root unit, and sits beside it in the FPU as its inverse operation. The 24×24 mantissa product is formed by an iterative radix-2 shift-add multiplier over 24 cycles. The block uses an act/done handshake. Special operands take a one-cycle fast path.

---
 rtl/fp_square_pkg.sv | 27 ++
 rtl/mant_mul_seq.sv | 49 ++++
 rtl/special_characters.v | 10 +
 rtl/fp_square.sv | 175 +++++++++++++++++
 tb/tb_fp_square.sv | 138 +++++++++++++
 5 files changed

// File: rtl/fp_square_pkg.sv
// Common definitions for the single-precision squaring unit.
package fp_square_pkg;

  `include "special_characters.v"

  localparam int W = 32;  // word width
  localparam int M = 22;  // MSB index of the stored mantissa
  localparam int E = 30;  // MSB index of the exponent

  // Number of shift-add steps for the 24-bit significand product.
  localparam logic [4:0] MUL_CYCLES = 5'd24;

  // Decide whether the truncated magnitude must be incremented.
  // Result sign is always positive, so RD truncates and RU rounds away.
  function automatic logic round_up(input logic [2:0] rm, input logic lsb,
                                    input logic g, input logic sticky);
    logic up;
    case (rm)
      RZ, RD:  up = 1'b0;
      RU:      up = g | sticky;
      RMM:     up = g;
      default: up = g & (sticky | lsb);  // RNE and unused encodings
    endcase
    return up;
  endfunction

endpackage

// File: rtl/mant_mul_seq.sv
// Iterative radix-2 shift-add multiplier for two 24-bit significands.
// Loads on start, then performs one conditional add per cycle for 24 cycles.
module mant_mul_seq
  import fp_square_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic        busy,
  output logic        last,
  output logic [47:0] p
);

  logic [47:0] mcand_reg;
  logic [23:0] mplier_reg;
  logic [4:0]  cnt_reg;
  logic [47:0] p_reg;

  // Load operands on start; otherwise accumulate one multiplier bit per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      p_reg      <= '0;
    end else if (start) begin
      mcand_reg  <= {24'd0, a};
      mplier_reg <= b;
      cnt_reg    <= MUL_CYCLES;
      p_reg      <= '0;
    end else if (cnt_reg != 5'd0) begin
      if (mplier_reg[0]) begin
        p_reg <= p_reg + mcand_reg;
      end
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg - 5'd1;
    end
  end

  assign busy = (cnt_reg != 5'd0);
  // High during the cycle whose closing edge performs the final add,
  // so the consumer can be ready for p on the very next cycle.
  assign last = (cnt_reg == 5'd1);
  assign p    = p_reg;

endmodule

// File: rtl/special_characters.v
// Shared floating-point constants: canonical special results and rounding-mode encodings.
localparam logic [31:0] FP_NANQ = 32'h7FC0_0000;
localparam logic [31:0] FP_INFP = 32'h7F80_0000;
localparam logic [31:0] FP_MAXP = 32'h7F7F_FFFF;

localparam logic [2:0] RNE = 3'b000;
localparam logic [2:0] RZ  = 3'b001;
localparam logic [2:0] RD  = 3'b010;
localparam logic [2:0] RU  = 3'b011;
localparam logic [2:0] RMM = 3'b100;

// File: rtl/fp_square.sv
// Single-precision IEEE-754 squaring unit with act/done handshake.
// Normal operands go through a 24-cycle sequential multiply and a rounding
// cycle; NaN, infinity, zero and subnormal operands take a one-cycle path.
module fp_square
  import fp_square_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         act,
  input  logic [W-1:0] in1,
  input  logic [2:0]   round_m,
  output logic [W-1:0] out,
  output logic         done,
  output logic         ov,
  output logic         un,
  output logic         inv,
  output logic         inexact
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] RND  = 2'd2;
  localparam logic [1:0] SPEC = 2'd3;

  logic [1:0]   state_reg;
  logic [E:0]   in_reg;       // sign is irrelevant to a square, so it is not kept
  logic [2:0]   rm_reg;
  logic [W-1:0] out_reg;
  logic         done_reg;
  logic         ov_reg, un_reg, inv_reg, inexact_reg;

  logic         in_special;
  logic         accept;
  logic         mul_start;
  logic         mul_busy;
  logic         mul_last;
  logic [47:0]  prod;
  logic         unused_sign;

  assign unused_sign = in1[W-1];

  // Exponent all ones (NaN/inf) or all zeros (zero/subnormal) bypasses the multiplier.
  assign in_special = (&in1[E:M+1]) | ~(|in1[E:M+1]);
  assign accept     = (state_reg == IDLE) && act;
  assign mul_start  = accept && !in_special && !mul_busy;

  mant_mul_seq u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     ({1'b1, in1[M:0]}),
    .b     ({1'b1, in1[M:0]}),
    .busy  (mul_busy),
    .last  (mul_last),
    .p     (prod)
  );

  logic signed [10:0] er_base;
  logic signed [10:0] er_norm;
  logic signed [10:0] er_fin;
  logic [22:0]        mant_norm;
  logic               g_bit;
  logic               sticky;
  logic               up;
  logic [23:0]        mant_sum;
  logic [W-1:0]       rnd_out;
  logic               rnd_ov, rnd_un, rnd_inexact;

  // Normalise the product, round, and resolve overflow/underflow.
  always_comb begin
    er_base = $signed({2'b00, in_reg[E:M+1], 1'b0}) - 11'sd127;
    if (prod[47]) begin
      mant_norm = prod[46:24];
      g_bit     = prod[23];
      sticky    = |prod[22:0];
      er_norm   = er_base + 11'sd1;
    end else begin
      mant_norm = prod[45:23];
      g_bit     = prod[22];
      sticky    = |prod[21:0];
      er_norm   = er_base;
    end
    up          = round_up(rm_reg, mant_norm[0], g_bit, sticky);
    mant_sum    = {1'b0, mant_norm} + {23'd0, up};
    // A carry out of the stored mantissa leaves it zero and bumps the exponent.
    er_fin      = er_norm + $signed({10'd0, mant_sum[23]});
    rnd_ov      = 1'b0;
    rnd_un      = 1'b0;
    rnd_inexact = g_bit | sticky;
    rnd_out     = {1'b0, er_fin[7:0], mant_sum[22:0]};
    if (er_fin > 11'sd254) begin
      rnd_ov      = 1'b1;
      rnd_inexact = 1'b1;
      rnd_out     = (rm_reg == RZ || rm_reg == RD) ? FP_MAXP : FP_INFP;
    end else if (er_fin < 11'sd1) begin
      rnd_un      = 1'b1;
      rnd_inexact = 1'b1;
      rnd_out     = '0;
    end
  end

  logic [W-1:0] spec_out;
  logic         spec_inv;

  // Fixed result for NaN, infinity and zero/subnormal operands.
  always_comb begin
    spec_out = '0;
    spec_inv = 1'b0;
    if (&in_reg[E:M+1]) begin
      if (|in_reg[M:0]) begin
        spec_out = FP_NANQ;
        spec_inv = ~in_reg[M];
      end else begin
        spec_out = FP_INFP;
      end
    end
  end

  // Control FSM and registered result/flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      in_reg      <= '0;
      rm_reg      <= '0;
      out_reg     <= '0;
      done_reg    <= 1'b0;
      ov_reg      <= 1'b0;
      un_reg      <= 1'b0;
      inv_reg     <= 1'b0;
      inexact_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            in_reg    <= in1[E:0];
            rm_reg    <= round_m;
            state_reg <= in_special ? SPEC : MUL;
          end
        end
        MUL: begin
          if (mul_last) begin
            state_reg <= RND;
          end
        end
        RND: begin
          out_reg     <= rnd_out;
          ov_reg      <= rnd_ov;
          un_reg      <= rnd_un;
          inv_reg     <= 1'b0;
          inexact_reg <= rnd_inexact;
          done_reg    <= 1'b1;
          state_reg   <= IDLE;
        end
        default: begin
          out_reg     <= spec_out;
          ov_reg      <= 1'b0;
          un_reg      <= 1'b0;
          inv_reg     <= spec_inv;
          inexact_reg <= 1'b0;
          done_reg    <= 1'b1;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  assign out     = out_reg;
  assign done    = done_reg;
  assign ov      = ov_reg;
  assign un      = un_reg;
  assign inv     = inv_reg;
  assign inexact = inexact_reg;

endmodule

// File: tb/tb_fp_square.sv
// Directed-vector bench for fp_square with hand-computed expected results.
module tb_fp_square;

  logic        clk;
  logic        rst;
  logic        act;
  logic [31:0] in1;
  logic [2:0]  round_m;
  logic [31:0] out;
  logic        done;
  logic        ov, un, inv, inexact;

  int checks;
  int passes;

  fp_square dut (
    .clk     (clk),
    .rst     (rst),
    .act     (act),
    .in1     (in1),
    .round_m (round_m),
    .out     (out),
    .done    (done),
    .ov      (ov),
    .un      (un),
    .inv     (inv),
    .inexact (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One operation: flags are {ov, un, inv, inexact}. When inject is set, a
  // second act with a different operand is pulsed mid-operation.
  task automatic run(input string tag, input logic [31:0] a, input logic [2:0] rm,
                     input logic [31:0] exp_out, input logic [3:0] exp_flags,
                     input int exp_lat, input bit inject);
    int lat;
    lat = 0;
    @(negedge clk);
    act = 1'b1; in1 = a; round_m = rm;
    @(posedge clk); #1;
    act = 1'b0; in1 = 32'h3F80_0000; round_m = 3'b001;
    while (done !== 1'b1 && lat < 40) begin
      if (inject && lat == 5) begin
        act = 1'b1; in1 = 32'h3FC0_0000;
      end else begin
        act = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    act = 1'b0;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " out"}, out, exp_out);
    check({tag, " flags"}, {28'd0, ov, un, inv, inexact}, {28'd0, exp_flags});
    $display("op %s in=%h rm=%0d out=%h flags=%b lat=%0d", tag, a, rm, out,
             {ov, un, inv, inexact}, lat);
    @(posedge clk); #1;
    check({tag, " done pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int dn;
    checks = 0; passes = 0;
    rst = 1'b1; act = 1'b0; in1 = '0; round_m = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out", out, 32'd0);
    check("reset flags", {28'd0, ov, un, inv, inexact}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    // Normal path
    run("3.0",      32'h4040_0000, 3'b000, 32'h4110_0000, 4'b0000, 25, 1'b0);
    run("-2.0",     32'hC000_0000, 3'b000, 32'h4080_0000, 4'b0000, 25, 1'b0);
    run("1.5",      32'h3FC0_0000, 3'b000, 32'h4010_0000, 4'b0000, 25, 1'b0);
    run("1+u RNe",  32'h3F80_0001, 3'b000, 32'h3F80_0002, 4'b0001, 25, 1'b0);
    run("1+u RZ",   32'h3F80_0001, 3'b001, 32'h3F80_0002, 4'b0001, 25, 1'b0);
    run("1+u RD",   32'h3F80_0001, 3'b010, 32'h3F80_0002, 4'b0001, 25, 1'b0);
    run("1+u RU",   32'h3F80_0001, 3'b011, 32'h3F80_0003, 4'b0001, 25, 1'b0);
    run("1+u RMM",  32'h3F80_0001, 3'b100, 32'h3F80_0002, 4'b0001, 25, 1'b0);
    run("1+u m7",   32'h3F80_0001, 3'b111, 32'h3F80_0002, 4'b0001, 25, 1'b0);
    run("sqrt2 RNe",32'h3FB5_04F3, 3'b000, 32'h3FFF_FFFF, 4'b0001, 25, 1'b0);
    run("sqrt2 RU", 32'h3FB5_04F3, 3'b011, 32'h4000_0000, 4'b0001, 25, 1'b0);
    run("ovf RNe",  32'h7F00_0000, 3'b000, 32'h7F80_0000, 4'b1001, 25, 1'b0);
    run("ovf RZ",   32'h7F00_0000, 3'b001, 32'h7F7F_FFFF, 4'b1001, 25, 1'b0);
    run("ovf RD",   32'h7F00_0000, 3'b010, 32'h7F7F_FFFF, 4'b1001, 25, 1'b0);
    run("ovf RU",   32'h7F00_0000, 3'b011, 32'h7F80_0000, 4'b1001, 25, 1'b0);
    run("ovf RMM",  32'h7F00_0000, 3'b100, 32'h7F80_0000, 4'b1001, 25, 1'b0);
    run("unf",      32'h1F80_0000, 3'b000, 32'h0000_0000, 4'b0101, 25, 1'b0);

    // Special operands
    run("sNaN",     32'h7F80_0001, 3'b000, 32'h7FC0_0000, 4'b0010, 1, 1'b0);
    run("qNaN",     32'h7FC0_0000, 3'b000, 32'h7FC0_0000, 4'b0000, 1, 1'b0);
    run("-inf",     32'hFF80_0000, 3'b000, 32'h7F80_0000, 4'b0000, 1, 1'b0);
    run("subn",     32'h0000_0001, 3'b000, 32'h0000_0000, 4'b0000, 1, 1'b0);
    run("-zero",    32'h8000_0000, 3'b011, 32'h0000_0000, 4'b0000, 1, 1'b0);

    // act during MUL is ignored
    run("3.0 inj",  32'h4040_0000, 3'b000, 32'h4110_0000, 4'b0000, 25, 1'b1);

    // Reset in the middle of a multiply
    @(negedge clk);
    act = 1'b1; in1 = 32'h4040_0000; round_m = 3'b000;
    @(posedge clk); #1;
    act = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst out", out, 32'd0);
    check("midrst flags", {28'd0, ov, un, inv, inexact}, 32'd0);
    dn = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    check("midrst no done", dn, 32'd0);
    $display("op midrst out=%h dones=%0d", out, dn);

    run("post rst", 32'h3FC0_0000, 3'b000, 32'h4010_0000, 4'b0000, 25, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
